// File: rtl/ucie_fdi_pkg.sv
// ============================================================================
// Module   : ucie_fdi_pkg
// Brief    : Shared types and helpers for the UCIe FDI receive-side blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ucie_fdi_pkg;

   // Width of a VC index for a given VC count (at least one bit).
   function automatic int vc_width(input int num_vcs);
      return (num_vcs > 1) ? $clog2(num_vcs) : 1;
   endfunction

   localparam int FDI_FLIT_WIDTH = 256;
   localparam int FDI_NUM_VCS    = 8;
   localparam int FDI_VC_WIDTH   = vc_width(FDI_NUM_VCS);

   // One flit as it travels toward the protocol layer (default geometry).
   typedef struct packed {
      logic [FDI_FLIT_WIDTH-1:0] data;
      logic                      sop;
      logic                      eop;
      logic [3:0]                be;
      logic [FDI_VC_WIDTH-1:0]   vc;
   } fdi_flit_t;

   // Packet framing tracker.
   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_IN_PKT = 1'b1
   } frame_state_t;

endpackage

`default_nettype wire

// File: rtl/ucie_sync_fifo.sv
// ============================================================================
// Module   : ucie_sync_fifo
// Brief    : Single-clock FIFO with occupancy count and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ucie_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign empty    = (r_count == '0);
   assign full     = (r_count == (AW+1)'(DEPTH));
   assign count    = r_count;
   assign pop_data = r_mem[r_rd_ptr];
   assign w_push   = push & ~full;
   assign w_pop    = pop & ~empty;

   // Pointer and occupancy tracking; flush empties the FIFO in one edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage; cleared on reset so the head reads as zero while empty.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push && !flush) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ucie_fdi_flit_sink.sv
// ============================================================================
// Module   : ucie_fdi_flit_sink
// Brief    : FDI receive endpoint: flit cancel staging, framing check,
//            protocol-layer FIFO and per-VC credit return.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ucie_fdi_flit_sink
   import ucie_fdi_pkg::*;
#(
   parameter int FLIT_WIDTH = 256,
   parameter int NUM_VCS    = 8,
   parameter int DEPTH      = 8,
   parameter int VC_LSB     = 0
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic                              link_up,
   input  logic                              lp_rx_active_req,
   output logic                              pl_rx_active_sts,
   input  logic                              pl_flit_valid,
   input  logic [FLIT_WIDTH-1:0]             pl_flit_data,
   input  logic                              pl_flit_sop,
   input  logic                              pl_flit_eop,
   input  logic [3:0]                        pl_flit_be,
   input  logic                              pl_flit_cancel,
   output logic                              lp_flit_ready,
   output logic [NUM_VCS-1:0]                lp_credit_return,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [FLIT_WIDTH-1:0]             out_data,
   output logic                              out_sop,
   output logic                              out_eop,
   output logic [3:0]                        out_be,
   output logic [vc_width(NUM_VCS)-1:0]      out_vc,
   output logic                              proto_err
);

   localparam int VCW = vc_width(NUM_VCS);
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int EW  = FLIT_WIDTH + 6 + VCW;

   logic                  r_rx_active_sts;
   logic                  r_stage_v;
   logic [FLIT_WIDTH-1:0] r_stage_data;
   logic                  r_stage_sop;
   logic                  r_stage_eop;
   logic [3:0]            r_stage_be;
   logic [VCW-1:0]        r_cur_vc;
   logic                  r_proto_err;
   logic [NUM_VCS-1:0]    r_credit;
   frame_state_t          r_state;
   frame_state_t          w_state_nxt;
   logic                  w_frame_err;

   logic                  w_ready;
   logic                  w_accept;
   logic                  w_commit;
   logic [VCW-1:0]        w_commit_vc;
   logic                  w_pop;
   logic [EW-1:0]         w_push_data;
   logic [EW-1:0]         w_head;
   logic [CW-1:0]         w_count;
   logic                  w_empty;
   logic                  w_full;

   // Occupancy includes the staged flit so a commit can never find the FIFO full.
   assign w_ready     = link_up & r_rx_active_sts &
                        ((w_count + CW'(r_stage_v)) < CW'(DEPTH));
   assign w_accept    = pl_flit_valid & w_ready;
   assign w_commit    = r_stage_v & ~pl_flit_cancel & link_up & ~w_full;
   assign w_commit_vc = r_stage_sop ? r_stage_data[VC_LSB +: VCW] : r_cur_vc;
   assign w_push_data = {w_commit_vc, r_stage_be, r_stage_eop, r_stage_sop, r_stage_data};
   assign w_pop       = ~w_empty & out_ready;

   // Rx-active status follows the request one cycle later while trained.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_rx_active_sts <= 1'b0;
      else         r_rx_active_sts <= lp_rx_active_req & link_up;
   end

   // One-flit staging register that holds a flit until its cancel window passes.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_stage_v    <= 1'b0;
         r_stage_data <= '0;
         r_stage_sop  <= 1'b0;
         r_stage_eop  <= 1'b0;
         r_stage_be   <= '0;
      end else if (!link_up) begin
         r_stage_v    <= 1'b0;
      end else begin
         r_stage_v <= w_accept;
         if (w_accept) begin
            r_stage_data <= pl_flit_data;
            r_stage_sop  <= pl_flit_sop;
            r_stage_eop  <= pl_flit_eop;
            r_stage_be   <= pl_flit_be;
         end
      end
   end

   // Current VC only moves on a committed SOP, so a cancelled SOP leaves it alone.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                       r_cur_vc <= '0;
      else if (!link_up)                 r_cur_vc <= '0;
      else if (w_commit && r_stage_sop)  r_cur_vc <= w_commit_vc;
   end

   // Framing state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Framing next-state and error detection on each committed flit.
   always_comb begin
      w_state_nxt = r_state;
      w_frame_err = 1'b0;
      if (!link_up) begin
         w_state_nxt = ST_IDLE;
      end else if (w_commit) begin
         w_frame_err = r_stage_sop ? (r_state == ST_IN_PKT) : (r_state == ST_IDLE);
         if (r_stage_eop)      w_state_nxt = ST_IDLE;
         else if (r_stage_sop) w_state_nxt = ST_IN_PKT;
      end
   end

   // Sticky framing error, cleared only by link-down.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)          r_proto_err <= 1'b0;
      else if (!link_up)    r_proto_err <= 1'b0;
      else if (w_frame_err) r_proto_err <= 1'b1;
   end

   // Credit pulse for the VC of a departing EOP; an issued pulse survives link-down.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_credit <= '0;
      end else begin
         r_credit <= '0;
         if (w_pop && out_eop && link_up) r_credit[out_vc] <= 1'b1;
      end
   end

   ucie_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (~link_up),
      .push      (w_commit),
      .push_data (w_push_data),
      .pop       (w_pop),
      .pop_data  (w_head),
      .count     (w_count),
      .empty     (w_empty),
      .full      (w_full)
   );

   assign {out_vc, out_be, out_eop, out_sop, out_data} = w_head;
   assign out_valid        = ~w_empty;
   assign lp_flit_ready    = w_ready;
   assign pl_rx_active_sts = r_rx_active_sts;
   assign lp_credit_return = r_credit;
   assign proto_err        = r_proto_err;

endmodule

`default_nettype wire
